// File: rtl/eth_rx_slot_buffer_pkg.sv
// Shared types and constants for the Ethernet receive slot buffer.
// No logic of its own; the CRC helper is a pure bit reversal.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DROP  = 3'd4
    } rx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    typedef struct packed {
        logic [15:0] len;
        logic        crc_ok;
    } slot_stat_t;

    // The running CRC is kept LSB-first; the residue constant is MSB-first.
    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_rx_slot_buffer_crc32_d8.sv
// CRC32 (poly 0x04C11DB7, reflected) next state for one byte, LSB first.
// Purely combinational, zero latency, no flow control.
module eth_crc32_d8 (
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    always_comb begin
        logic [31:0] c;
        c = i_crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ i_data[i]) begin
                c = (c >> 1) ^ 32'hEDB88320;
            end else begin
                c = c >> 1;
            end
        end
        o_crc = c;
    end

endmodule

// File: rtl/eth_rx_slot_buffer.sv
// RX MAC front end: strips preamble/SFD, checks FCS, packs frames into a ring of slots.
// Read data has 1-cycle latency; RX cannot be stalled, so frames arriving with all slots full are dropped.
module eth_rx_slot_buffer
    import eth_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int NUM_SLOTS = 4,
    parameter  int MAX_BYTES = 1536,
    parameter  int MIN_BYTES = 64,
    localparam int AW        = $clog2(MAX_BYTES * 8 / DATA_W)
) (
    input  logic              i_clk,
    input  logic              rst_n,
    input  logic              i_speed_1g,
    input  logic              i_rx_dv,
    input  logic [7:0]        i_rx_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_release,
    output logic              o_slot_valid,
    output logic [15:0]       o_slot_len,
    output logic              o_slot_crc_ok,
    output logic              o_irq,
    output logic [15:0]       o_drop_cnt
);

    localparam int BPW   = DATA_W / 8;
    localparam int LW    = $clog2(BPW);
    localparam int SW    = $clog2(NUM_SLOTS);
    localparam int DEPTH = NUM_SLOTS << AW;

    localparam logic [15:0] MAX_B    = 16'(MAX_BYTES);
    localparam logic [15:0] MIN_B    = 16'(MIN_BYTES);
    localparam logic [SW:0] FULL_CNT = (SW+1)'(NUM_SLOTS);

    rx_state_e         state_q, state_d;
    logic              speed_q, speed_d;
    logic              nib_phase_q, nib_phase_d;
    logic [3:0]        nib_lo_q, nib_lo_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]       crc_q, crc_d, crc_nxt;
    logic [DATA_W-1:0] word_q, word_d, word_ins;
    logic              odd_q, odd_d;
    logic [SW-1:0]     wr_slot_q, wr_slot_d;
    logic [SW-1:0]     rd_slot_q, rd_slot_d;
    logic [SW:0]       count_q, count_d;
    logic [15:0]       drop_q, drop_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              speed_eff;
    logic              byte_stb;
    logic [7:0]        byte_dat;
    logic [LW-1:0]     lane;
    logic [AW-1:0]     word_idx;
    logic              commit;
    logic              drop_inc;
    logic              rel;
    logic              mem_we;
    logic [SW+AW-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdat;
    slot_stat_t        stat_wdat;

    logic [DATA_W-1:0] mem [DEPTH];
    slot_stat_t        stat_q [NUM_SLOTS];

    // Speed is latched when leaving IDLE, but the very first nibble arrives in IDLE.
    always_comb begin
        speed_eff   = (state_q == ST_IDLE) ? i_speed_1g : speed_q;
        byte_stb    = 1'b0;
        byte_dat    = i_rx_data;
        nib_phase_d = 1'b0;
        nib_lo_d    = nib_lo_q;
        if (i_rx_dv) begin
            if (speed_eff) begin
                byte_stb = 1'b1;
            end else if (nib_phase_q) begin
                byte_stb = 1'b1;
                byte_dat = {i_rx_data[3:0], nib_lo_q};
            end else begin
                nib_lo_d    = i_rx_data[3:0];
                nib_phase_d = 1'b1;
            end
        end
    end

    eth_crc32_d8 u_crc (
        .i_crc  (crc_q),
        .i_data (byte_dat),
        .o_crc  (crc_nxt)
    );

    assign lane     = byte_cnt_q[LW-1:0];
    assign word_idx = byte_cnt_q[LW +: AW];

    always_comb begin
        state_d    = state_q;
        speed_d    = speed_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        word_d     = word_q;
        word_ins   = word_q;
        odd_d      = odd_q;
        commit     = 1'b0;
        drop_inc   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = {wr_slot_q, word_idx};
        mem_wdat   = word_q;

        case (state_q)
            ST_IDLE: begin
                speed_d = i_speed_1g;
                if (i_rx_dv) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                if (!i_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (byte_stb) begin
                    if (byte_dat == SFD_BYTE) begin
                        if (count_q < FULL_CNT) begin
                            state_d    = ST_DATA;
                            crc_d      = CRC_INIT;
                            byte_cnt_d = '0;
                            word_d     = '0;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end else if (byte_dat != PREAMBLE_BYTE) begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DATA: begin
                if (!i_rx_dv) begin
                    // A dangling low nibble means the frame ended mid-byte.
                    odd_d   = ~speed_q & nib_phase_q;
                    mem_we  = (lane != '0);
                    state_d = ST_CHECK;
                end else if (byte_stb) begin
                    if (byte_cnt_q == MAX_B) begin
                        state_d = ST_DROP;
                    end else begin
                        crc_d                   = crc_nxt;
                        byte_cnt_d              = byte_cnt_q + 16'd1;
                        word_ins[{lane, 3'b000} +: 8] = byte_dat;
                        if (lane == LW'(BPW - 1)) begin
                            mem_we   = 1'b1;
                            mem_wdat = word_ins;
                            word_d   = '0;
                        end else begin
                            word_d = word_ins;
                        end
                    end
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (byte_cnt_q < MIN_B) begin
                    drop_inc = 1'b1;
                end else begin
                    commit = 1'b1;
                end
            end
            ST_DROP: begin
                if (!i_rx_dv) begin
                    drop_inc = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign stat_wdat.len    = byte_cnt_q;
    assign stat_wdat.crc_ok = (bitrev32(crc_q) == CRC_RESIDUE) && !odd_q;

    assign rel = i_release && (count_q != '0);

    always_comb begin
        wr_slot_d = wr_slot_q;
        rd_slot_d = rd_slot_q;
        count_d   = count_q;
        drop_d    = drop_q;
        if (commit) begin
            wr_slot_d = wr_slot_q + 1'b1;
        end
        if (rel) begin
            rd_slot_d = rd_slot_q + 1'b1;
        end
        case ({commit, rel})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (drop_inc && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    assign rd_data_d = mem[{rd_slot_q, i_rd_addr}];

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            speed_q     <= 1'b0;
            nib_phase_q <= 1'b0;
            nib_lo_q    <= '0;
            byte_cnt_q  <= '0;
            crc_q       <= '0;
            word_q      <= '0;
            odd_q       <= 1'b0;
            wr_slot_q   <= '0;
            rd_slot_q   <= '0;
            count_q     <= '0;
            drop_q      <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            nib_phase_q <= nib_phase_d;
            nib_lo_q    <= nib_lo_d;
            byte_cnt_q  <= byte_cnt_d;
            crc_q       <= crc_d;
            word_q      <= word_d;
            odd_q       <= odd_d;
            wr_slot_q   <= wr_slot_d;
            rd_slot_q   <= rd_slot_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                stat_q[i] <= '0;
            end
        end else if (commit) begin
            stat_q[wr_slot_q] <= stat_wdat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdat;
        end
    end

    assign o_rd_data     = rd_data_q;
    assign o_slot_valid  = (count_q != '0);
    assign o_irq         = (count_q != '0);
    assign o_slot_len    = stat_q[rd_slot_q].len;
    assign o_slot_crc_ok = stat_q[rd_slot_q].crc_ok;
    assign o_drop_cnt    = drop_q;

endmodule

// File: tb/tb_eth_rx_slot_buffer.sv
// Directed bench for eth_rx_slot_buffer: frames built here with their own FCS, results checked by assertion.
`timescale 1ns/1ps
module tb_eth_rx_slot_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        speed = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [8:0]  rd_addr = '0;
    logic        rel = 1'b0;
    logic [31:0] rd_data;
    logic        slot_valid;
    logic [15:0] slot_len;
    logic        slot_crc_ok;
    logic        irq;
    logic [15:0] drop_cnt;

    int total  = 0;
    int passed = 0;

    logic [7:0] frm [0:1599];
    int         frm_len = 0;

    always #5 clk = ~clk;

    eth_rx_slot_buffer dut (
        .i_clk         (clk),
        .rst_n         (rst_n),
        .i_speed_1g    (speed),
        .i_rx_dv       (rx_dv),
        .i_rx_data     (rx_data),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .i_release     (rel),
        .o_slot_valid  (slot_valid),
        .o_slot_len    (slot_len),
        .o_slot_crc_ok (slot_crc_ok),
        .o_irq         (irq),
        .o_drop_cnt    (drop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // MSB-first CRC over bit-reversed bytes; FCS is the reflected, inverted register.
    task automatic build_frame(input int npay, input int seed);
        logic [31:0] c;
        logic [31:0] fcs;
        logic [7:0]  b;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < npay; i++) begin
            b = 8'((i * 13 + seed * 29 + 5) ^ (i >> 3));
            frm[i] = b;
            for (int k = 0; k < 8; k++) begin
                fb = c[31] ^ b[k];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        for (int k = 0; k < 32; k++) fcs[k] = ~c[31-k];
        for (int k = 0; k < 4; k++) frm[npay+k] = fcs[8*k +: 8];
        frm_len = npay + 4;
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (speed) begin
            @(negedge clk); rx_dv = 1'b1; rx_data = b;
        end else begin
            @(negedge clk); rx_dv = 1'b1; rx_data = {4'h0, b[3:0]};
            @(negedge clk); rx_data = {4'h0, b[7:4]};
        end
    endtask

    task automatic send_frame(input int nsend, input bit extra_nib, input bit end_dv);
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
        for (int i = 0; i < nsend; i++) send_byte(frm[i]);
        if (extra_nib) begin
            @(negedge clk); rx_data = 8'h0A;
        end
        if (end_dv) begin
            @(negedge clk); rx_dv = 1'b0; rx_data = 8'h00;
        end
    endtask

    task automatic release_head();
        @(negedge clk); rel = 1'b1;
        @(negedge clk); rel = 1'b0;
    endtask

    task automatic check_words(input string tag);
        logic [31:0] exp;
        int          idx;
        for (int w = 0; w < (frm_len + 3) / 4; w++) begin
            @(negedge clk); rd_addr = 9'(w);
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                idx = 4 * w + b;
                exp[8*b +: 8] = (idx < frm_len) ? frm[idx] : 8'h00;
            end
            check($sformatf("%s_w%0d", tag, w), rd_data, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [15:0] len, input logic ok);
        check({tag, "_valid"}, slot_valid, 1'b1);
        check({tag, "_len"}, slot_len, len);
        check({tag, "_crc"}, slot_crc_ok, ok);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", slot_valid, 1'b0);
        check("rst_len", slot_len, 16'd0);
        check("rst_crc", slot_crc_ok, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_drop", drop_cnt, 16'd0);
        check("rst_rdata", rd_data, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: good 64-byte frame at 1G
        build_frame(60, 1);
        send_frame(frm_len, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_valid_early", slot_valid, 1'b0);
        @(negedge clk);
        check_head("t1", 16'd64, 1'b1);
        check("t1_irq", irq, 1'b1);
        check_words("t1");
        release_head();
        check("t1_released", slot_valid, 1'b0);

        // 2: corrupted payload byte still commits with bad CRC
        build_frame(60, 2);
        frm[10] = ~frm[10];
        send_frame(frm_len, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_head("t2", 16'd64, 1'b0);
        check("t2_drop", drop_cnt, 16'd0);
        release_head();

        // 3: fill all slots, fifth frame is dropped, release then refill after wrap
        for (int f = 0; f < 5; f++) begin
            build_frame(60 + ((f < 4) ? f : 0), 10 + f);
            send_frame(frm_len, 1'b0, 1'b1);
            repeat (2) @(negedge clk);
        end
        check("t3_drop", drop_cnt, 16'd1);
        check_head("t3_a", 16'd64, 1'b1);
        release_head();
        check_head("t3_b", 16'd65, 1'b1);
        build_frame(70, 20);
        send_frame(frm_len, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("t3_f_drop", drop_cnt, 16'd1);
        release_head();
        check_head("t3_c", 16'd66, 1'b1);
        release_head();
        check_head("t3_d", 16'd67, 1'b1);
        release_head();
        check_head("t3_f", 16'd74, 1'b1);
        check_words("t3_f");
        release_head();
        check("t3_empty", slot_valid, 1'b0);

        // 4: oversize and runt frames are dropped
        build_frame(1596, 30);
        send_frame(frm_len, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("t4_big_drop", drop_cnt, 16'd2);
        check("t4_big_valid", slot_valid, 1'b0);
        build_frame(36, 31);
        send_frame(frm_len, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("t4_runt_drop", drop_cnt, 16'd3);
        check("t4_runt_valid", slot_valid, 1'b0);

        // 5: nibble mode, then an odd nibble count
        speed = 1'b0;
        build_frame(60, 1);
        send_frame(frm_len, 1'b0, 1'b1);
        @(negedge clk);
        check("t5_valid_early", slot_valid, 1'b0);
        @(negedge clk);
        check_head("t5", 16'd64, 1'b1);
        check_words("t5");
        release_head();
        send_frame(frm_len, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check_head("t5_odd", 16'd64, 1'b0);
        release_head();
        speed = 1'b1;

        // 6: reset mid-frame, then commit and release in the same cycle
        build_frame(60, 40);
        send_frame(frm_len, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("t6_pre_valid", slot_valid, 1'b1);
        build_frame(60, 41);
        send_frame(20, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; rx_dv = 1'b0; rx_data = 8'h00;
        #1;
        check("t6_rst_valid", slot_valid, 1'b0);
        check("t6_rst_len", slot_len, 16'd0);
        check("t6_rst_crc", slot_crc_ok, 1'b0);
        check("t6_rst_irq", irq, 1'b0);
        check("t6_rst_drop", drop_cnt, 16'd0);
        check("t6_rst_rdata", rd_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        build_frame(60, 42);
        send_frame(frm_len, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_head("t6_g", 16'd64, 1'b1);
        rd_addr = 9'd0;
        @(negedge clk);
        check("t6_g_w0", rd_data, {frm[3], frm[2], frm[1], frm[0]});
        build_frame(80, 43);
        send_frame(frm_len, 1'b0, 1'b1);
        @(negedge clk); rel = 1'b1;
        @(negedge clk); rel = 1'b0;
        check_head("t6_h", 16'd84, 1'b1);
        release_head();
        check("t6_empty", slot_valid, 1'b0);
        check("t6_drop", drop_cnt, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/eth_rx_slot_buffer.md
Name: eth_rx_slot_buffer

Overview:
Parametrised receive-side MAC front end. It takes the decoded RGMII stream (byte per clock at 1G, nibble per clock at 10/100), strips the preamble/SFD, and checks the FCS with CRC32. Frames are packed into a ring of NUM_SLOTS packet buffers with per-slot status. The block sits between the DDR input capture and the host/NIOS RX read port, and replaces the fixed single-buffer, 1G-only receive path with a multi-slot, dual-speed one.

Parameters:
DATA_W, 32, host read word width; multiple of 8 (32 or 64)
NUM_SLOTS, 4, number of packet buffers; power of 2, >=2
MAX_BYTES, 1536, buffer bytes per slot, FCS included; multiple of DATA_W/8
MIN_BYTES, 64, shortest frame accepted, FCS included

Ports:
i_clk  in  1  RX clock (PLL RX clock domain)
rst_n  in  1  asynchronous active-low reset
i_speed_1g  in  1  1 = byte per cycle on i_rx_data[7:0]; 0 = nibble per cycle on i_rx_data[3:0], low nibble first
i_rx_dv  in  1  receive data valid
i_rx_data  in  8  receive data
i_rd_addr  in  AW  word address in the head slot; AW = clog2(MAX_BYTES*8/DATA_W)
o_rd_data  out  DATA_W  head-slot word, 1-cycle read latency
i_release  in  1  single-cycle pulse; frees the head slot
o_slot_valid  out  1  head slot holds a committed frame
o_slot_len  out  16  head frame length in bytes, FCS included
o_slot_crc_ok  out  1  head frame FCS correct
o_irq  out  1  level IRQ; high while any slot is committed
o_drop_cnt  out  16  saturating count of dropped frames

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM to IDLE; write/read pointers, slot count, drop counter and nibble phase cleared. Buffer RAM contents are not reset.
- Lane assembly:
  - Nibble mode: the first nibble after i_rx_dv rises is the low half. A byte strobe fires every second nibble.
  - 1G mode: every dv cycle is a byte strobe.
  - i_speed_1g is sampled only in IDLE.
- FSM IDLE -> PRE -> DATA -> CHECK -> IDLE, plus DROP:
  - IDLE: on dv=1, go to PRE.
  - PRE: each byte 0x55 stays in PRE. Byte 0xD5 goes to DATA if slot count < NUM_SLOTS, otherwise to DROP. Any other byte goes to DROP. dv fall goes to IDLE with no count.
  - DATA: each byte strobe CRC-updates, packs little-endian (byte 0 in [7:0]) into the write word, and increments byte_cnt. A full word is written to mem[wr_slot][word]. Byte MAX_BYTES+1 goes to DROP.
  - On dv fall in DATA: flush the partial word, zero-padded, then go to CHECK.
  - CHECK (1 cycle):
    - byte_cnt < MIN_BYTES goes to IDLE and counts a drop.
    - Otherwise write len=byte_cnt and crc_ok, then advance wr_slot and increment count.
    - crc_ok = (CRC residue == 0xC704DD7B) and, in nibble mode, an even nibble count.
    - Frames with bad CRC are still committed, with crc_ok=0.
  - DROP: wait for dv=0, increment o_drop_cnt (saturating at 0xFFFF), go to IDLE. No slot state changes.
- Commit visibility: o_slot_valid/o_irq rise 1 cycle after CHECK (2 cycles after dv falls).
- Read port: o_rd_data = mem[rd_slot][i_rd_addr], registered. o_slot_len/o_slot_crc_ok always reflect rd_slot.
- Release:
  - i_release while o_slot_valid=1 advances rd_slot and decrements count the next cycle.
  - i_release while empty is ignored.
- Commit and release in the same cycle: both pointers advance and count is unchanged. A slot freed this way is usable by the next SFD.
- Pointers wrap modulo NUM_SLOTS.
- dv=1 while in CHECK does not start a frame; the FSM re-enters via IDLE.

Decomposition:
- eth_pkg: rx_state_e enum, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, CRC_RESIDUE=32'hC704DD7B, CRC_INIT=32'hFFFFFFFF, and the slot status struct {len[15:0], crc_ok}.
- Sub-module eth_crc32_d8: combinational 8-bit-per-step CRC32 next-state function (poly 0x04C11DB7, reflected), instantiated once.

Test Plan:
1. 1G mode: 7x 0x55, 0xD5, then a 60-byte payload plus valid FCS -> 2 cycles after dv falls: o_slot_valid=1, o_slot_len=64, o_slot_crc_ok=1, o_irq=1; words 0..15 read back match the payload+FCS, little-endian.
2. Same frame with payload byte 10 flipped -> committed with len=64, crc_ok=0, drop_cnt=0.
3. Five back-to-back good frames with no release -> 4 slots valid, drop_cnt=1. Then one i_release followed by a 6th frame -> accepted, slot count returns to 4, len/crc_ok correct after wrap.
4. 1600-byte frame -> no commit, drop_cnt+1. A 40-byte frame -> no commit (runt), drop_cnt+1.
5. i_speed_1g=0 with test 1's frame as nibbles -> identical len/crc_ok/data. The same frame with one extra nibble -> crc_ok=0.
6. rst_n pulsed low mid-DATA -> all outputs 0 immediately. The next good frame is received into slot 0 with len/crc_ok correct; commit and release in the same cycle keeps the count constant.
